// File: rtl/rf_drain_ctrl.sv
// Register-file drain engine: reads a contiguous, wrapping window of RF entries
// through a combinational read port and streams them out as valid/ready beats.
module rf_drain_ctrl #(
  parameter int phit_size    = 64,
  parameter int dwidth_RFadd = 5,
  parameter int depth_RF     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [dwidth_RFadd-1:0] base_addr,
  input  logic [dwidth_RFadd:0]   count,
  output logic [dwidth_RFadd-1:0] rf_rd_addr,
  input  logic [phit_size-1:0]    rf_rd_data,
  output logic [phit_size-1:0]    m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, STREAM, LAST} state_t;

  localparam logic [dwidth_RFadd:0]   DEPTH_C   = (dwidth_RFadd+1)'(depth_RF);
  localparam logic [dwidth_RFadd:0]   CNT_ONE   = (dwidth_RFadd+1)'(1);
  localparam logic [dwidth_RFadd-1:0] LAST_ADDR = dwidth_RFadd'(depth_RF - 1);
  localparam logic [dwidth_RFadd-1:0] ADDR_ONE  = dwidth_RFadd'(1);

  state_t                  state_reg, state_next;
  logic [dwidth_RFadd-1:0] rd_ptr_reg, rd_ptr_next;
  logic [dwidth_RFadd:0]   remaining_reg, remaining_next;
  logic [phit_size-1:0]    tdata_reg, tdata_next;
  logic                    tvalid_reg, tvalid_next;
  logic                    tlast_reg, tlast_next;
  logic                    done_reg, done_next;
  logic [dwidth_RFadd:0]   count_eff;
  logic                    handshake;

  // Wrap by explicit compare so non-power-of-two depths never touch invalid entries.
  function automatic logic [dwidth_RFadd-1:0] wrap_inc(input logic [dwidth_RFadd-1:0] a);
    if (a >= LAST_ADDR) return '0;
    else                return a + ADDR_ONE;
  endfunction

  assign count_eff = (count > DEPTH_C) ? DEPTH_C : count;
  assign handshake = tvalid_reg & m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && (count != '0))
          state_next = (count_eff == CNT_ONE) ? LAST : STREAM;
      end
      STREAM: begin
        if (handshake && (remaining_reg == CNT_ONE)) state_next = LAST;
      end
      LAST: begin
        if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // In IDLE the read port follows base_addr so the first entry lands on the start edge.
  always_comb begin
    rf_rd_addr     = (state_reg == IDLE) ? base_addr : rd_ptr_reg;
    busy           = (state_reg != IDLE);
    rd_ptr_next    = rd_ptr_reg;
    remaining_next = remaining_reg;
    tdata_next     = tdata_reg;
    tvalid_next    = tvalid_reg;
    tlast_next     = tlast_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_next = 1'b1;
          end else begin
            tdata_next     = rf_rd_data;
            tvalid_next    = 1'b1;
            tlast_next     = (count_eff == CNT_ONE);
            rd_ptr_next    = wrap_inc(base_addr);
            remaining_next = count_eff - CNT_ONE;
          end
        end
      end
      STREAM: begin
        if (handshake) begin
          tdata_next     = rf_rd_data;
          rd_ptr_next    = wrap_inc(rd_ptr_reg);
          remaining_next = remaining_reg - CNT_ONE;
          tlast_next     = (remaining_reg == CNT_ONE);
        end
      end
      LAST: begin
        if (handshake) begin
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          done_next   = 1'b1;
        end
      end
      default: begin
        tvalid_next = 1'b0;
        tlast_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      remaining_reg <= '0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      remaining_reg <= remaining_next;
      tdata_reg     <= tdata_next;
      tvalid_reg    <= tvalid_next;
      tlast_reg     <= tlast_next;
      done_reg      <= done_next;
    end
  end

  assign m_tdata  = tdata_reg;
  assign m_tvalid = tvalid_reg;
  assign m_tlast  = tlast_reg;
  assign done     = done_reg;

endmodule
